// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: state encodings, default geometry and next_state legalisation.
// Used by fifo_ptr_ctrl and the next-state decoder.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FIFO_AW    = 3;

  typedef enum logic [2:0] {
    INIT   = 3'b000,
    READ   = 3'b001,
    WRITE  = 3'b010,
    NO_OP  = 3'b011,
    RD_ERR = 3'b100,
    WR_ERR = 3'b101
  } state_e;

  // Codes 110/111 and any X/Z fall through to NO_OP.
  function automatic state_e legalise_state(input logic [2:0] code);
    state_e s;
    s = NO_OP;
    case (code)
      3'b000:  s = INIT;
      3'b001:  s = READ;
      3'b010:  s = WRITE;
      3'b011:  s = NO_OP;
      3'b100:  s = RD_ERR;
      3'b101:  s = WR_ERR;
      default: s = NO_OP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake/status bundle between the next-state decoder side and fifo_ptr_ctrl.
// Optional almost_full/almost_empty exist only when FIFO_PTR_CTRL_ALMOST_EN is defined.
interface fifo_ptr_ctrl_if #(
  parameter int unsigned AW = fifo_pkg::FIFO_AW
);
  logic [2:0]    next_state;
  logic [2:0]    state;
  logic [AW:0]   data_count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          we;
  logic          re;
  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
`ifdef FIFO_PTR_CTRL_ALMOST_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  modport master (
    output next_state,
    input  state, data_count, head, tail, we, re, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err
`ifdef FIFO_PTR_CTRL_ALMOST_EN
    , input almost_full, almost_empty
`endif
  );

  modport slave (
    input  next_state,
    output state, data_count, head, tail, we, re, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err
`ifdef FIFO_PTR_CTRL_ALMOST_EN
    , output almost_full, almost_empty
`endif
  );

endinterface

// File: rtl/fifo_flag_dec.sv
// Combinational decode of registered state/data_count into status and handshake flags.
// almost_full/almost_empty are added when FIFO_PTR_CTRL_ALMOST_EN is defined.
module fifo_flag_dec
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned AW    = FIFO_AW
) (
  input  state_e      state,
  input  logic [AW:0] data_count,
  output logic        full,
  output logic        empty,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        rd_ack,
  output logic        rd_err
`ifdef FIFO_PTR_CTRL_ALMOST_EN
  ,
  output logic        almost_full,
  output logic        almost_empty
`endif
);

  assign full   = (data_count == (AW+1)'(DEPTH));
  assign empty  = (data_count == '0);
  assign wr_ack = (state == WRITE);
  assign wr_err = (state == WR_ERR);
  assign rd_ack = (state == READ);
  assign rd_err = (state == RD_ERR);

`ifdef FIFO_PTR_CTRL_ALMOST_EN
  assign almost_full  = (data_count == (AW+1)'(DEPTH - 1));
  assign almost_empty = (data_count == (AW+1)'(1));
`endif

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Registered control stage of the FIFO: state, head/tail pointers and occupancy count.
// Optional almost flags are enabled with FIFO_PTR_CTRL_ALMOST_EN.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned AW    = FIFO_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  fifo_ptr_ctrl_if.slave bus
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_e        state_q;
  state_e        state_d;
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW:0]   count_q;
  logic          do_wr;
  logic          do_rd;

  // Overflow/underflow requests degrade to NO_OP for pointers and count only;
  // the state register still follows the request.
  always_comb begin
    state_d = legalise_state(bus.next_state);
    do_wr   = (state_d == WRITE) && (count_q != CNT_FULL);
    do_rd   = (state_d == READ)  && (count_q != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (do_wr) begin
        tail_q  <= tail_q + AW'(1);
        count_q <= count_q + (AW+1)'(1);
      end else if (do_rd) begin
        head_q  <= head_q + AW'(1);
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  assign bus.we         = (bus.next_state == WRITE);
  assign bus.re         = (bus.next_state == READ);
  assign bus.state      = state_q;
  assign bus.head       = head_q;
  assign bus.tail       = tail_q;
  assign bus.data_count = count_q;

  fifo_flag_dec #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_flag_dec (
    .state        (state_q),
    .data_count   (count_q),
    .full         (bus.full),
    .empty        (bus.empty),
    .wr_ack       (bus.wr_ack),
    .wr_err       (bus.wr_err),
    .rd_ack       (bus.rd_ack),
    .rd_err       (bus.rd_err)
`ifdef FIFO_PTR_CTRL_ALMOST_EN
    ,
    .almost_full  (bus.almost_full),
    .almost_empty (bus.almost_empty)
`endif
  );

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl; a reference model pushes expected observations per cycle.
// Define FIFO_PTR_CTRL_ALMOST_EN to also exercise the almost flags.
module tb_fifo_ptr_ctrl;
  import fifo_pkg::*;

  localparam int unsigned D = 8;
  localparam int unsigned A = 3;

  typedef struct packed {
    logic [2:0]   state;
    logic [A-1:0] head;
    logic [A-1:0] tail;
    logic [A:0]   count;
    logic         full;
    logic         empty;
    logic         wr_ack;
    logic         wr_err;
    logic         rd_ack;
    logic         rd_err;
`ifdef FIFO_PTR_CTRL_ALMOST_EN
    logic         almost_full;
    logic         almost_empty;
`endif
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifo_ptr_ctrl_if #(.AW(A)) bus ();

  fifo_ptr_ctrl #(
    .DEPTH (D),
    .AW    (A)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  obs_t        exp_q[$];

  logic [2:0]   m_state;
  logic [A-1:0] m_head;
  logic [A-1:0] m_tail;
  int unsigned  m_count;
  logic         seen_we;
  logic         seen_re;
  logic [2:0]   last_ns;

  function automatic obs_t model_obs();
    obs_t o;
    o = '0;
    o.state  = m_state;
    o.head   = m_head;
    o.tail   = m_tail;
    o.count  = (A+1)'(m_count);
    o.full   = (m_count == D);
    o.empty  = (m_count == 0);
    o.wr_ack = (m_state == 3'b010);
    o.wr_err = (m_state == 3'b101);
    o.rd_ack = (m_state == 3'b001);
    o.rd_err = (m_state == 3'b100);
`ifdef FIFO_PTR_CTRL_ALMOST_EN
    o.almost_full  = (m_count == D - 1);
    o.almost_empty = (m_count == 1);
`endif
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state  = bus.state;
    o.head   = bus.head;
    o.tail   = bus.tail;
    o.count  = bus.data_count;
    o.full   = bus.full;
    o.empty  = bus.empty;
    o.wr_ack = bus.wr_ack;
    o.wr_err = bus.wr_err;
    o.rd_ack = bus.rd_ack;
    o.rd_err = bus.rd_err;
`ifdef FIFO_PTR_CTRL_ALMOST_EN
    o.almost_full  = bus.almost_full;
    o.almost_empty = bus.almost_empty;
`endif
    return o;
  endfunction

  task automatic model_reset();
    m_state = 3'b000;
    m_head  = '0;
    m_tail  = '0;
    m_count = 0;
    exp_q.delete();
  endtask

  // Drive one next_state code at negedge, capture strobes, push the model's
  // expectation, then step past the accepting edge.
  task automatic apply(input logic [2:0] ns);
    @(negedge clk);
    bus.next_state = ns;
    last_ns = ns;
    #1;
    seen_we = bus.we;
    seen_re = bus.re;
    m_state = (ns <= 3'd5) ? ns : 3'b011;
    if (m_state == 3'b010 && m_count < D) begin
      m_tail  = m_tail + 3'd1;
      m_count = m_count + 1;
    end else if (m_state == 3'b001 && m_count > 0) begin
      m_head  = m_head + 3'd1;
      m_count = m_count - 1;
    end
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t g, e;
    logic [2:0] ops[3];
    ops = '{3'b010, 3'b010, 3'b001};
    foreach (ops[i]) begin
      apply(ops[i]);
      e = exp_q.pop_front();
      g = sample();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL reset_pre[%0d]: got %h want %h", i, g, e);
      end
    end
    @(negedge clk);
    bus.next_state = 3'b010;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    e = '0;
    e.empty = 1'b1;
    g = sample();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", g, e);
    end
    n_cmp++;
    if ({bus.we, bus.re} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_we_re: got %b want 10", {bus.we, bus.re});
    end
    bus.next_state = 3'b011;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    obs_t g, e;
    for (int i = 0; i < 10; i++) begin
      apply((i == 9) ? 3'b101 : 3'b010);
      e = exp_q.pop_front();
      g = sample();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL fill[%0d]: got %h want %h", i, g, e);
      end
      n_cmp++;
      if ({seen_we, seen_re} !== {last_ns == 3'b010, 1'b0}) begin
        n_bad++;
        $display("FAIL fill_we[%0d]: got %b want %b", i, {seen_we, seen_re}, {last_ns == 3'b010, 1'b0});
      end
    end
    n_cmp++;
    if ({bus.tail, bus.data_count, bus.full, bus.wr_err} !== {3'd0, 4'd8, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL fill_end: got tail=%0d cnt=%0d full=%b wr_err=%b want 0 8 1 1",
               bus.tail, bus.data_count, bus.full, bus.wr_err);
    end
  endtask

  task automatic test_drain();
    obs_t g, e;
    for (int i = 0; i < 9; i++) begin
      apply((i == 8) ? 3'b100 : 3'b001);
      e = exp_q.pop_front();
      g = sample();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL drain[%0d]: got %h want %h", i, g, e);
      end
      n_cmp++;
      if ({seen_we, seen_re} !== {1'b0, last_ns == 3'b001}) begin
        n_bad++;
        $display("FAIL drain_re[%0d]: got %b want %b", i, {seen_we, seen_re}, {1'b0, last_ns == 3'b001});
      end
    end
    n_cmp++;
    if ({bus.head, bus.tail, bus.data_count, bus.empty, bus.rd_err} !== {3'd0, 3'd0, 4'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL drain_end: got head=%0d tail=%0d cnt=%0d empty=%b rd_err=%b want 0 0 0 1 1",
               bus.head, bus.tail, bus.data_count, bus.empty, bus.rd_err);
    end
  endtask

  task automatic test_wrap();
    obs_t g, e;
    logic [2:0] ns;
    for (int i = 0; i < 14; i++) begin
      ns = (i >= 5 && i < 8) ? 3'b001 : 3'b010;
      apply(ns);
      e = exp_q.pop_front();
      g = sample();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got %h want %h", i, g, e);
      end
    end
    n_cmp++;
    if ({bus.head, bus.tail, bus.data_count, bus.full} !== {3'd3, 3'd3, 4'd8, 1'b1}) begin
      n_bad++;
      $display("FAIL wrap_end: got head=%0d tail=%0d cnt=%0d full=%b want 3 3 8 1",
               bus.head, bus.tail, bus.data_count, bus.full);
    end
  endtask

  task automatic test_illegal();
    obs_t g, e;
    logic [2:0] ops[6];
    ops = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b111, 3'b110};
    foreach (ops[i]) begin
      apply(ops[i]);
      e = exp_q.pop_front();
      g = sample();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL illegal[%0d]: got %h want %h", i, g, e);
      end
      if (i >= 4) begin
        n_cmp++;
        if ({seen_we, seen_re, bus.state, bus.data_count, bus.head, bus.tail} !==
            {2'b00, 3'b011, 4'd4, 3'd7, 3'd3}) begin
          n_bad++;
          $display("FAIL illegal_hold[%0d]: got we/re=%b st=%b cnt=%0d h=%0d t=%0d want 00 011 4 7 3",
                   i, {seen_we, seen_re}, bus.state, bus.data_count, bus.head, bus.tail);
        end
      end
    end
  endtask

`ifdef FIFO_PTR_CTRL_ALMOST_EN
  task automatic test_almost();
    obs_t g, e;
    for (int i = 0; i < 9; i++) begin
      apply((i < 3) ? 3'b001 : 3'b010);
      e = exp_q.pop_front();
      g = sample();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL almost[%0d]: got %h want %h", i, g, e);
      end
      if (i == 2) begin
        n_cmp++;
        if ({bus.data_count, bus.almost_empty, bus.almost_full} !== {4'd1, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL almost_empty: got cnt=%0d ae=%b af=%b want 1 1 0",
                   bus.data_count, bus.almost_empty, bus.almost_full);
        end
      end
    end
    n_cmp++;
    if ({bus.data_count, bus.almost_empty, bus.almost_full} !== {4'd7, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL almost_full: got cnt=%0d ae=%b af=%b want 7 0 1",
               bus.data_count, bus.almost_empty, bus.almost_full);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.next_state = 3'b011;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_illegal();
`ifdef FIFO_PTR_CTRL_ALMOST_EN
    test_almost();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
